// File: rtl/segre_main_memory.sv
// Behavioural main memory behind the MMU: lane refill reads and a FIFO write buffer drained ahead of reads.
// Optional misaligned-store rejection is enabled with `define SEGRE_MM_MISALIGN_CHECK_EN.
package segre_mm_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;
endpackage

module segre_main_memory
  import segre_mm_pkg::*;
#(
  parameter int ADDR_SIZE        = 32,
  parameter int WORD_SIZE        = 32,
  parameter int DCACHE_LANE_SIZE = 128,
  parameter int MEM_SIZE_BYTES   = 65536,
  parameter int LANE_SIZE        = DCACHE_LANE_SIZE,
  parameter int RD_LATENCY       = 4,
  parameter int WR_LATENCY       = 2,
  parameter int WBUF_DEPTH       = 4
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_SIZE-1:0]  rd_addr_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_SIZE-1:0]  wr_addr_i,
  input  memop_data_type_e      wr_data_type_i,
  input  logic [WORD_SIZE-1:0]  wr_data_i,
  output logic                  data_rdy_o,
  output logic [LANE_SIZE-1:0]  data_o,
  output logic                  wr_full_o,
  output logic                  wr_ovf_o,
  output logic                  busy_o,
  output logic                  misalign_o
);

  localparam int MEM_AW     = $clog2(MEM_SIZE_BYTES);
  localparam int LANE_BYTES = LANE_SIZE / 8;
  localparam int PW         = $clog2(WBUF_DEPTH);
  localparam int CW         = PW + 1;
  localparam int MAXLAT     = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNTW       = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_e;

  logic [7:0] mem [MEM_SIZE_BYTES];

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pop, commit, rd_done;

  logic [MEM_AW-1:0]    buf_addr [WBUF_DEPTH];
  memop_data_type_e     buf_type [WBUF_DEPTH];
  logic [WORD_SIZE-1:0] buf_data [WBUF_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, push, misaligned, ovf;

  logic [MEM_AW-1:0]    cur_addr;
  memop_data_type_e     cur_type;
  logic [WORD_SIZE-1:0] cur_data;
  logic [3:0]           cur_be;

  logic                 rd_pend;
  logic [MEM_AW-1:0]    rd_base;
  logic [LANE_SIZE-1:0] lane, data_q;
  logic                 data_rdy_q;

  logic                 unused_bits;
  assign unused_bits = ^{rd_addr_i, wr_addr_i};

`ifdef SEGRE_MM_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misaligned = wr_req_i &&
                      (((wr_data_type_i == HALF) && wr_addr_i[0]) ||
                       ((wr_data_type_i == WORD) && (wr_addr_i[1:0] != 2'b00)));

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) misalign_q <= 1'b0;
    else        misalign_q <= misaligned;
  end
  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // full reflects the count before the edge, so a push at full is dropped even when a pop happens
  assign full = (count == CW'(WBUF_DEPTH));
  assign push = wr_req_i && !full && !misaligned;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req_i && full && !misaligned) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr[wr_ptr] <= wr_addr_i[MEM_AW-1:0];
      buf_type[wr_ptr] <= wr_data_type_i;
      buf_data[wr_ptr] <= wr_data_i;
    end
    if (pop) begin
      cur_addr <= buf_addr[rd_ptr];
      cur_type <= buf_type[rd_ptr];
      cur_data <= buf_data[rd_ptr];
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stores always win over a pending read so refills observe every earlier store
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    commit  = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = WR_BUSY;
          cnt_d   = CNTW'(WR_LATENCY - 1);
        end else if (rd_pend) begin
          state_d = RD_BUSY;
          cnt_d   = CNTW'(RD_LATENCY - 1);
        end
      end
      WR_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (cur_type)
      BYTE:    cur_be = 4'b0001;
      HALF:    cur_be = 4'b0011;
      WORD:    cur_be = 4'b1111;
      default: cur_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_be[k]) mem[cur_addr + MEM_AW'(k)] <= cur_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    lane = '0;
    for (int i = 0; i < LANE_BYTES; i++) begin
      lane[8*i +: 8] = mem[rd_base + MEM_AW'(i)];
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_pend    <= 1'b0;
      rd_base    <= '0;
      data_q     <= '0;
      data_rdy_q <= 1'b0;
    end else begin
      data_rdy_q <= rd_done;
      if (rd_done) begin
        rd_pend <= 1'b0;
        data_q  <= lane;
      end else if (rd_req_i && !rd_pend) begin
        rd_pend <= 1'b1;
        rd_base <= rd_addr_i[MEM_AW-1:0] & ~MEM_AW'(LANE_BYTES - 1);
      end
    end
  end

`ifndef SYNTHESIS
  a_single_read: assert property (@(posedge clk_i) disable iff (!rsn_i) !(rd_req_i && rd_pend));
`endif

  assign data_rdy_o = data_rdy_q;
  assign data_o     = data_q;
  assign wr_full_o  = full;
  assign wr_ovf_o   = ovf;
  assign busy_o     = rd_pend || (count != '0) || (state_q != IDLE);

endmodule

// File: doc/segre_main_memory.md
Name: segre_main_memory

Overview:
Behavioural main-memory controller that sits directly downstream of the cache-subsystem MMU. It serves lane-sized refill reads for the instruction and data caches and accepts word/half/byte store traffic. Stores are queued in a small FIFO write buffer and drained before any read, so a refill always sees every earlier store. Latencies are fixed and parameterised.

Parameters:
MEM_SIZE_BYTES, 65536, memory capacity in bytes; power of two; addresses taken modulo this.
LANE_SIZE, DCACHE_LANE_SIZE (128), read lane width in bits.
RD_LATENCY, 4, cycles spent in RD_BUSY per lane read; must be >=1.
WR_LATENCY, 2, cycles spent in WR_BUSY per store; must be >=1.
WBUF_DEPTH, 4, write-buffer entries; power of two, >=2.

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, asynchronous, active-low
rd_req_i  in  1  lane read request, one-cycle pulse
rd_addr_i  in  ADDR_SIZE  read byte address; low log2(LANE_SIZE/8) bits ignored
wr_req_i  in  1  store request, one per cycle
wr_addr_i  in  ADDR_SIZE  store byte address
wr_data_type_i  in  memop_data_type_e  BYTE / HALF / WORD
wr_data_i  in  WORD_SIZE  store data, right-aligned
data_rdy_o  out  1  read data valid, one-cycle pulse
data_o  out  LANE_SIZE  read lane data
wr_full_o  out  1  write buffer full
wr_ovf_o  out  1  sticky: a store was dropped because the buffer was full
busy_o  out  1  read pending, or buffer non-empty, or state != IDLE
misalign_o  out  1  misaligned-store pulse (tied 0 without the macro)

Behaviour:
- Reset (async, rsn_i=0): state=IDLE; buffer emptied; read-pending flag cleared; latency counter cleared.
- Reset values of outputs: data_rdy_o=0, data_o=0, wr_full_o=0, wr_ovf_o=0, busy_o=0, misalign_o=0.
- Memory array contents are not reset and survive reset.
- Reset mid-operation: the in-flight store is not committed and the pending read is discarded. No data_rdy_o pulse follows reset release.
- Store accept: wr_req_i=1 and wr_full_o=0 at an edge pushes {addr, type, data}.
- Store at full: wr_full_o reflects the count before the edge. A push while full is dropped and sets wr_ovf_o, even if a pop happens on the same edge. A simultaneous push and pop when not full leaves the count unchanged.
- wr_full_o is 1 exactly when count==WBUF_DEPTH.
- Read accept: rd_req_i=1 sets the pending flag and latches the lane-aligned address. A rd_req_i while a read is already pending is ignored (simulation assertion fires). Only one read is outstanding at a time.
- FSM states: IDLE, WR_BUSY, RD_BUSY.
- IDLE: if the buffer is non-empty, pop the head, go to WR_BUSY, set cnt=WR_LATENCY-1. Else if a read is pending, go to RD_BUSY, set cnt=RD_LATENCY-1. Else stay in IDLE. Stores always take priority over reads.
- WR_BUSY: while cnt!=0, decrement. At cnt==0, commit the store to the array and return to IDLE.
- RD_BUSY: while cnt!=0, decrement. At cnt==0, register the lane into data_o, pulse data_rdy_o for one cycle, clear the pending flag, return to IDLE.
- data_o holds its value until the next read completes.
- Latency, idle block with empty buffer:
  - read sampled at edge 0 -> data_rdy_o=1 after edge RD_LATENCY+1;
  - store sampled at edge 0 -> committed at edge WR_LATENCY+1.
- Store formatting, little-endian:
  - BYTE writes wr_data_i[7:0] at addr;
  - HALF writes [15:0] at addr..addr+1;
  - WORD writes [31:0] at addr..addr+3.
  - Byte addresses wrap modulo MEM_SIZE_BYTES.
- Lane read: byte i of data_o = mem[(lane_addr+i) mod MEM_SIZE_BYTES]; byte 0 sits at data_o[7:0].

Optional Feature:
SEGRE_MM_MISALIGN_CHECK_EN:
- Defined: a HALF store with addr[0]!=0, or a WORD store with addr[1:0]!=0, is not pushed and pulses misalign_o for one cycle on the accept edge. Such a store does not count toward full/ovf.
- Undefined: misalign_o is tied 0 and misaligned stores are written byte-wise as specified above.

Test Plan:
1. Reset; SW 0xDEADBEEF @0x100 at edge 0; rd_req @0x104 at edge 1 -> commit at edge 3, RD_BUSY entered at edge 4, data_rdy_o=1 after edge 8 for exactly one cycle, data_o[31:0]=0xDEADBEEF.
2. SW 0 @0x200, SH 0x2233 @0x200, SB 0x11 @0x203; read 0x208 -> data_o[31:0]=0x11002233.
3. 5 back-to-back SW while FSM is busy with a read (depth 4) -> wr_full_o=1 after the 4th accept, 5th dropped, wr_ovf_o=1 sticky until reset; a later read shows only the first 4 stores.
4. 3 SW to lane 0x300 (words 0..2 = 1,2,3) then rd_req same cycle as 3rd -> data_rdy_o not before all 3 commits (>=3*(WR_LATENCY+1) edges), data_o[95:0]=0x00000003_00000002_00000001.
5. rd_req, then rsn_i=0 while in RD_BUSY -> data_rdy_o=0, busy_o=0 immediately; after release, no data_rdy_o within 20 cycles; earlier committed data still readable.
6. With SEGRE_MM_MISALIGN_CHECK_EN: SH @0x401 -> misalign_o pulse, buffer count unchanged, memory unmodified. Without it: bytes 0x401..0x402 written.
